// File: rtl/clock_gen_pkg.sv
// -----------------------------------------------------------------------------
// clock_gen_pkg
// Shared definitions for the programmable clock divider.
//   DIV_W   : default divisor width
//   div_t   : divisor type, logic [DIV_W-1:0]
//   sat_div : maps a divisor of 0 to 1 (0 is treated as "divide by one")
// -----------------------------------------------------------------------------
package clock_gen_pkg;

  localparam int DIV_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  function automatic div_t sat_div(input div_t d);
    return (d == '0) ? div_t'(1) : d;
  endfunction

endpackage

// File: rtl/clock_gen_phase.sv
// -----------------------------------------------------------------------------
// clock_gen_phase
// Phase counter and terminal-count compare for clock_gen. The counter advances
// while run is high and wraps to 0 on terminal count; while run is low it is
// held at 0 so a restart always begins a full phase.
// Ports:
//   clock  : reference clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   run    : advance the counter this cycle
//   n_act  : active divisor (never 0)
//   tc     : combinational terminal-count pulse, cnt == n_act-1 while running
// -----------------------------------------------------------------------------
module clock_gen_phase
  import clock_gen_pkg::*;
#(
  parameter int DIV_W = clock_gen_pkg::DIV_W
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] n_act,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  assign tc = run && (cnt == (n_act - DIV_W'(1)));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clock_gen.sv
// -----------------------------------------------------------------------------
// clock_gen
// Programmable clock divider producing the registered, 50 % duty strobe clock
// CLK from the reference clock. Each high or low phase lasts N reference
// cycles of the divisor active when the phase began, so CLK period is 2*N.
// New divisors are held pending and only take effect at a phase boundary.
// Optional feature: define CLOCK_GEN_CNT_EN to add the 32-bit period_cnt port.
// Ports:
//   clock      : reference clock (rising edge)
//   rst_n      : asynchronous active-low reset; forces CLK low immediately
//   en         : run enable; when low, a high phase finishes then CLK parks low
//   div        : new divisor N (0 is treated as 1)
//   div_load   : single-cycle strobe capturing div
//   CLK        : divided clock output
//   rise       : one-cycle pulse on the edge that drives CLK high
//   fall       : one-cycle pulse on the edge that drives CLK low
//   busy       : a loaded divisor is pending and not yet active
//   period_cnt : completed CLK periods (only with CLOCK_GEN_CNT_EN)
// -----------------------------------------------------------------------------
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int DIV_W       = clock_gen_pkg::DIV_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  output logic             CLK,
  output logic             rise,
  output logic             fall,
  output logic             busy
`ifdef CLOCK_GEN_CNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] n_act;
  logic [DIV_W-1:0] n_pend;
  logic [DIV_W-1:0] div_sat;
  logic             run;
  logic             tc;

  // A divisor of 0 behaves as divide-by-one.
  assign div_sat = (div == '0) ? DIV_W'(1) : div;

  // The counter keeps running while CLK is high even with en low, so the
  // current high phase completes before CLK parks low. With CLK low and en
  // low the counter is held at 0, so no rising edge can be produced.
  assign run = en | CLK;

  clock_gen_phase #(
    .DIV_W (DIV_W)
  ) u_phase (
    .clock (clock),
    .rst_n (rst_n),
    .run   (run),
    .n_act (n_act),
    .tc    (tc)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      CLK    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      busy   <= 1'b0;
      n_act  <= DEF_DIV;
      n_pend <= DEF_DIV;
    end else begin
      // tc with CLK low implies en is high, so a low-to-high toggle can only
      // happen while enabled.
      rise <= tc & ~CLK;
      fall <= tc &  CLK;

      if (tc) begin
        CLK <= ~CLK;
      end

      if (div_load) begin
        n_pend <= div_sat;
      end

      // A load landing on the boundary bypasses the pending register so the
      // very next phase already uses it.
      if (tc) begin
        n_act <= div_load ? div_sat : n_pend;
      end

      if (div_load && !tc) begin
        busy <= 1'b1;
      end else if (tc) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef CLOCK_GEN_CNT_EN
  // Counts completed periods; updates on the same edge as the fall pulse and
  // wraps naturally at 2^32.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (tc && CLK) begin
      period_cnt <= period_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_gen
// Directed self-checking bench for clock_gen (DIV_W=8, DEFAULT_DIV=2).
// Outputs are sampled 1 time unit after each rising reference edge.
// -----------------------------------------------------------------------------
module tb_clock_gen;

  logic       clock;
  logic       rst_n;
  logic       en;
  logic [7:0] div;
  logic       div_load;
  logic       CLK;
  logic       rise;
  logic       fall;
  logic       busy;
`ifdef CLOCK_GEN_CNT_EN
  logic [31:0] period_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clock_gen #(
    .DIV_W       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .en         (en),
    .div        (div),
    .div_load   (div_load),
    .CLK        (CLK),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy)
`ifdef CLOCK_GEN_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts reference edges until CLK changes (bounded).
  task automatic measure(output int len);
    logic s;
    s   = CLK;
    len = 0;
    do begin
      tick();
      len++;
    end while (CLK === s && len < 64);
  endtask

  initial begin
    int   len;
    int   k;
    logic rise_seen;
    logic clk_seen;

    rst_n    = 1'b0;
    en       = 1'b1;
    div      = 8'd0;
    div_load = 1'b0;
    repeat (2) tick();

    // Reset values
    check("rst_clk",  32'(CLK),  32'd0);
    check("rst_rise", 32'(rise), 32'd0);
    check("rst_fall", 32'(fall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef CLOCK_GEN_CNT_EN
    check("rst_pcnt", period_cnt, 32'd0);
`endif

    // Default N=2: rise at edge 2, fall at edge 4
    rst_n = 1'b1;
    tick(); check("e1_clk",  32'(CLK),  32'd0);
    tick(); check("e2_clk",  32'(CLK),  32'd1);
            check("e2_rise", 32'(rise), 32'd1);
    tick(); check("e3_clk",  32'(CLK),  32'd1);
            check("e3_rise", 32'(rise), 32'd0);
    tick(); check("e4_clk",  32'(CLK),  32'd0);
            check("e4_fall", 32'(fall), 32'd1);
    tick();
    tick(); check("e6_clk",  32'(CLK),  32'd1);

    // Load 5 one edge into a high phase at N=2
    div = 8'd5; div_load = 1'b1;
    tick(); div_load = 1'b0;
    check("ld5_busy", 32'(busy), 32'd1);
    check("ld5_clk",  32'(CLK),  32'd1);
    tick();
    check("ld5_bnd_clk",  32'(CLK),  32'd0);
    check("ld5_bnd_busy", 32'(busy), 32'd0);
    measure(len); check("ld5_low",  32'(len), 32'd5);
    measure(len); check("ld5_high", 32'(len), 32'd5);

    // Load 3 coincident with a terminal count (low phase, edge 5 of 5)
    repeat (4) tick();
    check("co_pre_clk", 32'(CLK), 32'd0);
    div = 8'd3; div_load = 1'b1;
    tick(); div_load = 1'b0;
    check("co_clk",  32'(CLK),  32'd1);
    check("co_rise", 32'(rise), 32'd1);
    check("co_busy", 32'(busy), 32'd0);
    measure(len); check("co_high", 32'(len), 32'd3);
    check("co_busy2", 32'(busy), 32'd0);
    measure(len); check("co_low",  32'(len), 32'd3);

    // Load 0 at the start of a high phase: finishes N=3 phase, then N=1
    div = 8'd0; div_load = 1'b1;
    tick(); div_load = 1'b0;
    check("z_busy", 32'(busy), 32'd1);
    measure(len); check("z_tail", 32'(len), 32'd2);
    check("z_busy_clr", 32'(busy), 32'd0);
    measure(len); check("z_ph1", 32'(len), 32'd1);
    measure(len); check("z_ph2", 32'(len), 32'd1);

    // N=4 loaded on a terminal count (every edge is one at N=1)
    div = 8'd4; div_load = 1'b1;
    tick(); div_load = 1'b0;
    check("n4_busy", 32'(busy), 32'd0);
    k = 0;
    while (rise !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("n4_rise_found", 32'(rise), 32'd1);

    // Drop en one edge into the high phase: 3 more high cycles, then park
    tick();
    en = 1'b0;
    measure(len); check("stop_high_rem", 32'(len), 32'd3);
    check("stop_fall", 32'(fall), 32'd1);
    check("stop_clk",  32'(CLK),  32'd0);
    rise_seen = 1'b0;
    clk_seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      rise_seen |= rise;
      clk_seen  |= CLK;
    end
    check("park_rise", 32'(rise_seen), 32'd0);
    check("park_clk",  32'(clk_seen),  32'd0);

    // Re-enable: rise on the 4th enabled edge
    en = 1'b1;
    measure(len); check("restart_len",  32'(len),  32'd4);
    check("restart_rise", 32'(rise), 32'd1);

    // Fresh reset, divide by one (0 loaded), period count, async reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    div = 8'd0; div_load = 1'b1;
    tick(); div_load = 1'b0;
    check("cr_busy", 32'(busy), 32'd1);
    tick();
    check("cr_e2_clk", 32'(CLK), 32'd1);
    repeat (19) tick();
    check("cr_e21_clk",  32'(CLK),  32'd0);
    check("cr_e21_fall", 32'(fall), 32'd1);
`ifdef CLOCK_GEN_CNT_EN
    check("cr_pcnt10", period_cnt, 32'd10);
`endif
    tick();
    check("cr_e22_clk", 32'(CLK), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clk",  32'(CLK),  32'd0);
    check("arst_rise", 32'(rise), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
`ifdef CLOCK_GEN_CNT_EN
    check("arst_pcnt", period_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
